// File: rtl/riscv_instr_aligner.sv
// Instruction realignment stage between the prefetch buffer and the
// compressed decoder. Word-aligned fetch words go in, one instruction per
// handshake comes out. A compressed instruction leaves zero-extended. A
// 32-bit instruction that straddles two fetch words is rebuilt from the held
// upper halfword (residue_q) and the lower halfword of the next word.
module riscv_instr_aligner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_ready_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i
);

  typedef enum logic [1:0] {
    ALIGNED, // next instruction starts at W[15:0]
    MIS16,   // residue_q holds a complete compressed instruction
    MIS32,   // residue_q holds the lower half of a 32-bit instruction
    BR_MIS   // branch target is the upper halfword of W
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] residue_q, residue_d;
  logic [31:0] pc_q, pc_d;
  logic        acc;
  logic        lo_full; // W[15:0] opens a 32-bit instruction
  logic        hi_full; // W[31:16] opens a 32-bit instruction

  assign lo_full      = (fetch_rdata_i[1:0] == 2'b11);
  assign hi_full      = (fetch_rdata_i[17:16] == 2'b11);
  assign acc          = instr_valid_o & instr_ready_i;
  assign instr_addr_o = pc_q;

  // Output mux: the instruction presented by the current state, with no
  // gating of the data path in non-valid cycles.
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    instr_valid_o = 1'b0;
    instr_rdata_o = {16'h0, fetch_rdata_i[15:0]};
    case (state_q)
      ALIGNED: begin
        instr_valid_o = fetch_valid_i;
        instr_rdata_o = lo_full ? fetch_rdata_i : {16'h0, fetch_rdata_i[15:0]};
      end
      MIS16: begin
        instr_valid_o = 1'b1;
        instr_rdata_o = {16'h0, residue_q};
      end
      MIS32: begin
        instr_valid_o = fetch_valid_i;
        instr_rdata_o = {fetch_rdata_i[15:0], residue_q};
      end
      BR_MIS: begin
        instr_valid_o = fetch_valid_i & ~hi_full;
        instr_rdata_o = {16'h0, fetch_rdata_i[31:16]};
      end
      default: ;
    endcase
    // The redirect cycle never hands an instruction to the decoder.
    if (branch_i) instr_valid_o = 1'b0;
  end

  // Next-state logic: fetch consumption, residue capture and PC advance.
  always_comb begin
    fetch_ready_o = 1'b0;
    state_d       = state_q;
    residue_d     = residue_q;
    pc_d          = pc_q;
    if (branch_i) begin
      // Redirect wins over everything; any held halfword is stale.
      pc_d      = branch_addr_i & ~32'h1;
      residue_d = 16'h0;
      state_d   = branch_addr_i[1] ? BR_MIS : ALIGNED;
    end else begin
      if (acc) pc_d = pc_q + ((instr_rdata_o[1:0] == 2'b11) ? 32'd4 : 32'd2);
      case (state_q)
        ALIGNED: begin
          if (acc) begin
            fetch_ready_o = 1'b1;
            if (!lo_full) begin
              residue_d = fetch_rdata_i[31:16];
              state_d   = hi_full ? MIS32 : MIS16;
            end
          end
        end
        MIS16: begin
          if (acc) state_d = ALIGNED;
        end
        MIS32: begin
          if (acc) begin
            fetch_ready_o = 1'b1;
            residue_d     = fetch_rdata_i[31:16];
            state_d       = hi_full ? MIS32 : MIS16;
          end
        end
        BR_MIS: begin
          if (!hi_full) begin
            if (acc) begin
              fetch_ready_o = 1'b1;
              state_d       = ALIGNED;
            end
          end else if (fetch_valid_i) begin
            // Target opens a straddling instruction: swallow the word
            // without emitting anything and keep pc_q on the target.
            fetch_ready_o = 1'b1;
            residue_d     = fetch_rdata_i[31:16];
            state_d       = MIS32;
          end
        end
        default: state_d = ALIGNED;
      endcase
    end
  end

  // State, residue and PC registers; reset drops any held halfword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ALIGNED;
      residue_q <= 16'h0;
      pc_q      <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      residue_q <= residue_d;
      pc_q      <= pc_d;
    end
  end

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Directed self-checking bench for riscv_instr_aligner. Inputs change 1ns
// after the rising edge and outputs are sampled a few ns later, well away
// from the next rising edge.
module tb_riscv_instr_aligner;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_ready_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;

  int checks = 0;
  int errors = 0;

  riscv_instr_aligner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid_i (fetch_valid_i),
    .fetch_rdata_i (fetch_rdata_i),
    .fetch_ready_o (fetch_ready_o),
    .instr_valid_o (instr_valid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_addr_o  (instr_addr_o),
    .instr_ready_i (instr_ready_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One branch cycle; the instruction on the bus (if any) must be refused.
  task automatic do_branch(input logic [31:0] target, input string tag);
    branch_i      = 1'b1;
    branch_addr_i = target;
    instr_ready_i = 1'b1;
    #3;
    checks++;
    if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_branch_cycle: valid=%b ready=%b expected valid=0 ready=0",
               tag, instr_valid_o, fetch_ready_o);
    end
    tick();
    branch_i = 1'b0;
  endtask

  // Present a word, sample after settling and compare the full output set.
  task automatic expect_out(input logic fv, input logic [31:0] w,
                            input logic ev, input logic [31:0] ed,
                            input logic [31:0] ea, input logic efr,
                            input string tag);
    fetch_valid_i = fv;
    fetch_rdata_i = w;
    #3;
    checks++;
    if (instr_valid_o !== ev || fetch_ready_o !== efr ||
        (ev && (instr_rdata_o !== ed || instr_addr_o !== ea))) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h a=%h fr=%b expected v=%b d=%h a=%h fr=%b",
               tag, instr_valid_o, instr_rdata_o, instr_addr_o, fetch_ready_o,
               ev, ed, ea, efr);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 || instr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b fr=%b a=%h expected v=0 fr=0 a=00000000",
               instr_valid_o, fetch_ready_o, instr_addr_o);
    end
    tick();
  endtask

  task automatic test_aligned_stream();
    do_branch(32'h100, "aligned");
    expect_out(1, 32'h00A00093, 1, 32'h00A00093, 32'h100, 1, "aligned_w0"); tick();
    expect_out(1, 32'h00B00113, 1, 32'h00B00113, 32'h104, 1, "aligned_w1"); tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic test_packed_pair();
    do_branch(32'h0, "packed");
    expect_out(1, 32'h45014581, 1, 32'h00004581, 32'h0, 1, "packed_lo"); tick();
    expect_out(0, 32'h0,        1, 32'h00004501, 32'h2, 0, "packed_hi"); tick();
  endtask

  task automatic test_straddle();
    do_branch(32'h0, "straddle");
    expect_out(1, 32'h00934581, 1, 32'h00004581, 32'h0, 1, "straddle_c"); tick();
    expect_out(1, 32'h123400A0, 1, 32'h00A00093, 32'h2, 1, "straddle_32"); tick();
    expect_out(0, 32'h0,        1, 32'h00001234, 32'h6, 0, "straddle_tail"); tick();
  endtask

  task automatic test_branch_misaligned();
    do_branch(32'h202, "mis_c");
    expect_out(1, 32'h4581ABCD, 1, 32'h00004581, 32'h202, 1, "mis_c_out"); tick();
    // Back in ALIGNED: with no fetch word there is no instruction.
    expect_out(0, 32'h0, 0, 32'h0, 32'h0, 0, "mis_c_aligned");
    checks++;
    if (instr_addr_o !== 32'h204) begin
      errors++;
      $display("FAIL mis_c_pc: got %h expected 00000204", instr_addr_o);
    end
    do_branch(32'h206, "mis_32");
    expect_out(1, 32'h0093ABCD, 0, 32'h0, 32'h0, 1, "mis_32_skip"); tick();
    expect_out(1, 32'h000000A0, 1, 32'h00A00093, 32'h206, 1, "mis_32_out"); tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_branch(32'h206, "bp");
    expect_out(1, 32'h0093ABCD, 0, 32'h0, 32'h0, 1, "bp_skip"); tick();
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out(1, 32'h000000A0, 1, 32'h00A00093, 32'h206, 0, "bp_hold"); tick();
    end
    instr_ready_i = 1'b1;
    expect_out(1, 32'h000000A0, 1, 32'h00A00093, 32'h206, 1, "bp_release"); tick();
    // Exactly one accept: pc moved by 4, now in MIS16 with residue 0x0000.
    expect_out(0, 32'h0, 1, 32'h00000000, 32'h20A, 0, "bp_after");
  endtask

  task automatic test_flush();
    do_branch(32'h206, "flush");
    expect_out(1, 32'h0093ABCD, 0, 32'h0, 32'h0, 1, "flush_skip"); tick();
    // MIS32 with residue 0x0093; redirect with a word and ready both present.
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h000000A0;
    do_branch(32'h300, "flush_mid");
    expect_out(1, 32'h00C00193, 1, 32'h00C00193, 32'h300, 1, "flush_new"); tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic test_pc_wrap();
    // Bit 0 of the target is dropped; the PC wraps past 0xFFFFFFFC.
    do_branch(32'hFFFF_FFFD, "wrap");
    expect_out(1, 32'h00A00093, 1, 32'h00A00093, 32'hFFFF_FFFC, 1, "wrap_last"); tick();
    expect_out(1, 32'h00B00113, 1, 32'h00B00113, 32'h0, 1, "wrap_zero"); tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_branch(32'h40, "rst");
    expect_out(1, 32'h45014581, 1, 32'h00004581, 32'h40, 1, "rst_pre"); tick();
    fetch_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 || instr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b fr=%b a=%h expected v=0 fr=0 a=00000000",
               instr_valid_o, fetch_ready_o, instr_addr_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // After a fresh boot jump the aligner starts clean in ALIGNED.
    do_branch(32'h80, "rst_boot");
    expect_out(1, 32'h00A00093, 1, 32'h00A00093, 32'h80, 1, "rst_boot_out"); tick();
    fetch_valid_i = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_rdata_i = 32'h0;
    instr_ready_i = 1'b1;
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_aligned_stream();
    test_packed_pair();
    test_straddle();
    test_branch_misaligned();
    test_backpressure();
    test_flush();
    test_pc_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
